truth_table_sweeper: RTL
========================

// Module: truth_table_sweeper
// PURPOSE
//  Self-checking exhaustive sweeper for small combinational logic functions.
//  - Steps a registered N_IN-bit input vector through all 2**N_IN combinations.
//  - Compares N_CH DUT outputs (e.g. SOP and POS realisations) against a golden truth table.
//  - Reports pass/fail, total mismatch count and first failing vector/channel.
//  - Replaces hand-written per-vector testbench sequences.
// PARAMETERS
//  N_IN           4  number of function inputs; 1..8
//  N_CH           2  number of DUT output channels checked in parallel; 1..8
//  SETTLE_CYCLES  1  extra cycles each vector is held before sampling; 0..15
// PORTS
//  clk           in   1             rising-edge clock
//  rst           in   1             synchronous, active-high reset
//  start         in   1             begin sweep; honoured only in IDLE or DONE
//  golden_tt     in   2**N_IN       expected output; bit k = f(vector k); latched at start
//  vec_out       out  N_IN          stimulus; bit N_IN-1 = first variable (A)
//  dut_out       in   N_CH          DUT responses to vec_out, one bit per channel
//  busy          out  1             sweep in progress
//  done          out  1             sweep finished; level, held until next start/rst
//  pass          out  1             done && mismatch_cnt==0
//  mismatch_cnt  out  CNT_W         total mismatches; CNT_W = N_IN+$clog2(N_CH)+1, cannot overflow
//  fail_mask     out  N_CH          sticky per-channel fail flags
//  first_fail_vec  out N_IN         vector of first mismatch; 0 if none
//  first_fail_ch   out $clog2(N_CH)+1  lowest failing channel at first mismatch; 0 if none
//  first_fail_vld  out 1            first_fail_* valid
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. Reset mid-sweep aborts immediately; nothing retained.
//  - States:
//    IDLE  -start-> SWEEP
//    SWEEP -last vector sampled-> DONE
//    DONE  -start-> SWEEP
//  - start while busy is ignored.
//  - On accepted start (next edge):
//    - latch golden_tt; vec_out=0; settle_cnt=0
//    - clear mismatch_cnt, fail_mask, first_fail_*, done
//    - busy=1
//  - Each vector is held SETTLE_CYCLES+1 cycles.
//  - dut_out is sampled at the edge where settle_cnt==SETTLE_CYCLES; at that edge:
//    - compare each channel against latched golden[vec_out]
//    - add popcount(fails) to mismatch_cnt
//    - OR fails into fail_mask
//    - if !first_fail_vld and fails!=0: capture vec_out and the lowest failing index
//    - then vec_out++ and settle_cnt=0
//  - Last vector (all ones):
//    - no wrap-around; at the sampling edge go to DONE: busy=0, done=1
//    - vec_out holds all ones
//    - pass is valid from the same cycle
//  - Sweep latency: start edge to done=1 is 2**N_IN*(SETTLE_CYCLES+1) cycles.
//  - golden_tt changes during SWEEP have no effect.
//  - start in the same cycle as the final sample is ignored.
//  - rst has priority over start.
// CONFIGURATION
//  STOP_ON_FAIL_EN
//   - defined: the first sampling edge with any mismatch goes directly to DONE.
//     - done=1, pass=0; vec_out holds the failing vector.
//     - counts reflect only vectors checked so far.
//   - undefined: always sweeps all 2**N_IN vectors.
// STRUCTURE
//  - Shared package logic_lab_pkg:
//    - sweep state typedef (IDLE, SWEEP, DONE)
//    - MAX_N_IN=8 and MAX_N_CH=8 limits
//    - popcount function
//  - Sub-module tt_channel_cmp (one instance per channel, generate loop):
//    - registered golden bit select + XOR compare
//    - sticky fail flag
//  - Top holds FSM, vector/settle counters, mismatch accumulator, first-fail capture.
// TESTING
//  1. N_IN=3, SETTLE=1, golden=8'h67; both channels correct (!A!B+!BC+B!C and (!A+B+C)(!B+!C))
//     -> done after 16 cycles, pass=1, mismatch_cnt=0, fail_mask=0.
//  2. As 1, channel 1 stuck-at-0
//     -> mismatch_cnt=5, fail_mask=2'b10, first_fail_vec=3'd0, first_fail_ch=1, pass=0.
//  3. As 2 with STOP_ON_FAIL_EN
//     -> done 2 cycles after start, vec_out=0, mismatch_cnt=1, pass=0.
//  4. rst held 1 cycle at cycle 5 of sweep -> next cycle busy=0, done=0, vec_out=0, counts 0.
//     start pulsed mid-sweep -> ignored, sweep length unchanged.
//  5. N_IN=4, SETTLE=0, golden=16'hA5C3, DUT = golden LUT; golden_tt flipped to 0 mid-sweep
//     -> done after 16 cycles, pass=1.
//  6. Back-to-back: start again in DONE -> counters cleared, second sweep identical to first.

Source files
------------

// File: rtl/logic_lab_pkg.sv
// Shared definitions for the logic-lab sweeper blocks: sweep state encoding,
// configuration limits and a channel popcount helper.
package logic_lab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_e;

    localparam int MAX_N_IN = 8;
    localparam int MAX_N_CH = 8;
    localparam int PC_W     = $clog2(MAX_N_CH + 1);

    // Number of set bits in a channel fail vector (unused upper bits are zero).
    function automatic logic [PC_W-1:0] popcount(input logic [MAX_N_CH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_N_CH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper and its environment: sweep control,
// golden table, stimulus/response and the result reporting signals.
// The master side is the sweeper; the slave side is the environment that
// drives start/golden_tt and returns the DUT responses.
interface truth_table_sweeper_if #(
    parameter int N_IN = 4,
    parameter int N_CH = 2
);
    localparam int CNT_W = N_IN + $clog2(N_CH) + 1;
    localparam int FCH_W = $clog2(N_CH) + 1;

    logic                 start;
    logic [2**N_IN-1:0]   golden_tt;
    logic [N_IN-1:0]      vec_out;
    logic [N_CH-1:0]      dut_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CNT_W-1:0]     mismatch_cnt;
    logic [N_CH-1:0]      fail_mask;
    logic [N_IN-1:0]      first_fail_vec;
    logic [FCH_W-1:0]     first_fail_ch;
    logic                 first_fail_vld;

    modport master (
        input  start, golden_tt, dut_out,
        output vec_out, busy, done, pass, mismatch_cnt, fail_mask,
               first_fail_vec, first_fail_ch, first_fail_vld
    );

    modport slave (
        output start, golden_tt, dut_out,
        input  vec_out, busy, done, pass, mismatch_cnt, fail_mask,
               first_fail_vec, first_fail_ch, first_fail_vld
    );
endinterface

// File: rtl/tt_channel_cmp.sv
// One checked output channel: compares the DUT bit against the golden bit
// selected for the current vector and keeps a sticky fail flag.
// The golden table register lives in the top; this block sees the selected bit.
module tt_channel_cmp (
    input  logic clk,
    input  logic rst,
    input  logic clear,       // accepted start: forget previous sweep
    input  logic sample,      // sampling edge for the current vector
    input  logic golden_bit,
    input  logic dut_bit,
    output logic fail,        // mismatch at this sampling edge
    output logic fail_flag    // sticky since the last clear
);
    logic fail_flag_q;
    logic fail_flag_d;

    assign fail      = sample & (dut_bit ^ golden_bit);
    assign fail_flag = fail_flag_q;

    // Sticky flag: cleared by start, accumulates mismatches while sampling.
    always_comb begin
        fail_flag_d = fail_flag_q;
        if (clear) begin
            fail_flag_d = 1'b0;
        end else if (fail) begin
            fail_flag_d = 1'b1;
        end
    end

    // Flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_flag_q <= 1'b0;
        end else begin
            fail_flag_q <= fail_flag_d;
        end
    end
endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: steps vec_out through all 2**N_IN input
// combinations, holds each for SETTLE_CYCLES+1 cycles, and checks N_CH DUT
// output bits against a golden table latched at start.
// Optional build macro STOP_ON_FAIL_EN ends the sweep at the first sampling
// edge that sees any mismatch; without it every vector is always checked.
module truth_table_sweeper
    import logic_lab_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int N_CH          = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    truth_table_sweeper_if.master bus
);
    localparam int N_VEC = 2**N_IN;
    localparam int CNT_W = N_IN + $clog2(N_CH) + 1;
    localparam int FCH_W = $clog2(N_CH) + 1;

    sweep_state_e     state_q, state_d;
    logic [N_VEC-1:0] golden_q, golden_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [3:0]       settle_q, settle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  ff_vec_q, ff_vec_d;
    logic [FCH_W-1:0] ff_ch_q, ff_ch_d;
    logic             ff_vld_q, ff_vld_d;

    logic             start_ok;
    logic             sample;
    logic             last_vec;
    logic             sweep_end;
    logic             golden_bit;
    logic [N_CH-1:0]  fails;
    logic [N_CH-1:0]  fail_flags;
    logic [FCH_W-1:0] fail_idx;
    logic [PC_W-1:0]  fail_pc;

    // start is only honoured outside a sweep; rst priority comes from the register.
    assign start_ok   = bus.start && (state_q != ST_SWEEP);
    assign sample     = (state_q == ST_SWEEP) && (settle_q == 4'(SETTLE_CYCLES));
    assign last_vec   = &vec_q;
    assign golden_bit = golden_q[vec_q];
    assign fail_pc    = popcount(MAX_N_CH'(fails));

`ifdef STOP_ON_FAIL_EN
    assign sweep_end = last_vec || (fails != '0);
`else
    assign sweep_end = last_vec;
`endif

    genvar c;
    generate
        for (c = 0; c < N_CH; c++) begin : g_ch
            tt_channel_cmp u_cmp (
                .clk        (clk),
                .rst        (rst),
                .clear      (start_ok),
                .sample     (sample),
                .golden_bit (golden_bit),
                .dut_bit    (bus.dut_out[c]),
                .fail       (fails[c]),
                .fail_flag  (fail_flags[c])
            );
        end
    endgenerate

    // Lowest-numbered failing channel at this sampling edge.
    always_comb begin
        fail_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (fails[i]) begin
                fail_idx = FCH_W'(i);
            end
        end
    end

    // Sweep FSM with vector/settle counters, mismatch accumulator and first-fail capture.
    always_comb begin
        state_d  = state_q;
        golden_d = golden_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        ff_vec_d = ff_vec_q;
        ff_ch_d  = ff_ch_q;
        ff_vld_d = ff_vld_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d  = ST_SWEEP;
                    golden_d = bus.golden_tt;
                    vec_d    = '0;
                    settle_d = '0;
                    cnt_d    = '0;
                    ff_vec_d = '0;
                    ff_ch_d  = '0;
                    ff_vld_d = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (sample) begin
                    cnt_d = cnt_q + CNT_W'(fail_pc);
                    if (!ff_vld_q && (fails != '0)) begin
                        ff_vld_d = 1'b1;
                        ff_vec_d = vec_q;
                        ff_ch_d  = fail_idx;
                    end
                    if (sweep_end) begin
                        // vec_out holds the last checked vector in DONE.
                        state_d = ST_DONE;
                    end else begin
                        vec_d    = vec_q + 1'b1;
                        settle_d = '0;
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any sweep and clears results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            golden_q <= '0;
            vec_q    <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            ff_vec_q <= '0;
            ff_ch_q  <= '0;
            ff_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            golden_q <= golden_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            ff_vec_q <= ff_vec_d;
            ff_ch_q  <= ff_ch_d;
            ff_vld_q <= ff_vld_d;
        end
    end

    assign bus.vec_out        = vec_q;
    assign bus.busy           = (state_q == ST_SWEEP);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.pass           = (state_q == ST_DONE) && (cnt_q == '0);
    assign bus.mismatch_cnt   = cnt_q;
    assign bus.fail_mask      = fail_flags;
    assign bus.first_fail_vec = ff_vec_q;
    assign bus.first_fail_ch  = ff_ch_q;
    assign bus.first_fail_vld = ff_vld_q;
endmodule
